serdes_frame_scheduler: RTL and testbench
=========================================

SERDES_FRAME_SCHEDULER -- requirements
Module: serdes_frame_scheduler

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-low. Ports are clk and rst_n.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 req0_valid / req1_valid  in  1  requester N has a byte pair pending.
REQ-005 req0_a, req0_b / req1_a, req1_b  in  8 each  plaintext operand bytes, serialized MSB first.
REQ-006 req0_ready / req1_ready  out  1  grant; a byte pair is accepted when valid and ready are both high.
REQ-007 rsp_valid  out  1  result available.
REQ-008 rsp_data  out  8  ciphertext byte.
REQ-009 rsp_id  out  1  requester that owns the result.
REQ-010 rsp_err  out  1  core failed to complete.
REQ-011 rsp_ready  in  1  consumer accepts the result.
REQ-012 core_start, core_a_bit, core_b_bit  out  1  drive the encryptor core.
REQ-013 core_cipher, core_done  in  1  encryptor core outputs.
REQ-014 core_rst  out  1  active-high encryptor core reset.
REQ-015 core_key  out  128  key bus to the core; only bits [7:0] are consumed.
REQ-016 key_load  in  1  load key_in.
REQ-017 key_in  in  128  new key value.

Function
REQ-018 FSM states SHALL be IDLE, START, SHIFT, WAIT, CAPTURE, CHECK, RESPOND, RECOVER.
REQ-019 IDLE: reqN_ready SHALL equal the combinational round-robin grant; it SHALL be 0 in every other state.
REQ-020 Arbitration: when both requesters are valid, the grant SHALL go to the requester not served last; a lone valid requester SHALL always win.
REQ-021 On accept (cycle A), the scheduler SHALL latch a, b and id, then enter START; START is cycle C0 = A+1, with core_start=1 for exactly that cycle.
REQ-022 Cycles C1..C8: core_a_bit and core_b_bit SHALL present a[7-k] and b[7-k] in cycle C(k+1); both SHALL be 0 outside SHIFT.
REQ-023 Cycles C9..C10: WAIT state.
REQ-024 Cycles C11..C18: CAPTURE state; core_cipher SHALL be shifted in MSB first at the end of each cycle.
REQ-025 Cycle C18: core_done SHALL be sampled at the same time as the last cipher bit.
REQ-026 core_done=1 in C18: the scheduler SHALL enter RESPOND; rsp_valid=1 from C19 with rsp_err=0 and the captured byte.
REQ-027 Successful frame: core_key SHALL rotate right by 8 bits, so the next frame uses the next key byte.
REQ-028 core_done=0 in C18: the scheduler SHALL enter RECOVER, assert core_rst for 2 cycles, then enter RESPOND with rsp_err=1 and rsp_data=0x00; core_key SHALL be unchanged.
REQ-029 RESPOND: rsp_valid, rsp_data, rsp_id and rsp_err SHALL hold stable until rsp_ready=1; the scheduler then returns to IDLE the next cycle.
REQ-030 No grant SHALL occur while rsp_valid=1.
REQ-031 Best-case latency SHALL be 20 cycles from accept to rsp_valid (C19).
REQ-032 key_load SHALL be honoured only in IDLE, where it takes priority over grants that cycle (no ready asserted); it is ignored in all other states.
REQ-033 Width rule: there is no arithmetic beyond the 5-bit frame cycle counter, which SHALL saturate and never wrap within a frame.

Reset
REQ-034 While rst_n=0 at a clock edge:
- state=IDLE, round-robin pointer set so req0 wins first
- all outputs 0 except core_rst=1
- core_key=128'hA1B2C3D4E5F60123456789ABCDEF1234
REQ-035 Reset mid-frame SHALL abandon the frame with no response issued.
REQ-036 core_rst SHALL be the combination of (~rst_n) and the RECOVER state.

Structure
REQ-037 Package serdes_sched_pkg SHALL hold:
- FSM state enum
- timing constants CAP_FIRST=11, CAP_LAST=18, RECOVER_LEN=2
- DEFAULT_KEY
REQ-038 Sub-module rr_arbiter2 SHALL implement the 2-way round-robin grant and its last-served pointer.
REQ-039 Expected implementation size: 150-300 lines of RTL.

Verification
REQ-040 After reset, req0 A=0xF0, B=0x0F, paired with a behavioural core model -> rsp_valid at A+20, rsp_data=0xCB, rsp_id=0, rsp_err=0; core_key[7:0] becomes 0x12.
REQ-041 Second frame, A=0x00, B=0x00 -> rsp_data=0x12.
REQ-042 req0 and req1 valid in the same cycle after reset -> req0 served first, then req1; rsp_id sequence 0, 1.
REQ-043 rsp_ready held low for 10 cycles -> rsp fields stable, req ready stays 0, no core_start.
REQ-044 Core model with done stuck at 0 -> core_rst high for exactly 2 cycles, rsp_err=1, rsp_data=0x00, core_key unchanged.
REQ-045 Reset in C5, then key_load with key_in low byte 0x55, then A=0x01, B=0x00 -> no stale response; rsp_data=0x54.

Source files
------------

// File: rtl/serdes_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serdes_sched_pkg
//  Description : Shared types and frame timing constants for the SERDES
//                frame scheduler and its round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package serdes_sched_pkg;

  // Scheduler FSM states, explicitly 3 bits wide
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_CHECK   = 3'd5,
    ST_RESPOND = 3'd6,
    ST_RECOVER = 3'd7
  } state_e;

  // Frame cycle numbering: C0 = START, C1..C8 = SHIFT, C9..C10 = WAIT,
  // C11..C18 = CAPTURE, then RECOVER occupies C19..C20 on a failed frame.
  localparam logic [4:0] SHIFT_LAST   = 5'd8;
  localparam logic [4:0] WAIT_LAST    = 5'd10;
  localparam logic [4:0] CAP_FIRST    = 5'd11;
  localparam logic [4:0] CAP_LAST     = 5'd18;
  localparam logic [4:0] RECOVER_LEN  = 5'd2;
  localparam logic [4:0] RECOVER_EXIT = CAP_LAST + RECOVER_LEN;
  localparam logic [4:0] CYC_MAX      = 5'd31;

  localparam logic [127:0] DEFAULT_KEY = 128'hA1B2C3D4E5F60123456789ABCDEF1234;

  // Frame cycle counter step; holds at the top value instead of wrapping
  function automatic logic [4:0] cyc_inc(input logic [4:0] cyc);
    return (cyc == CYC_MAX) ? cyc : cyc + 5'd1;
  endfunction

  // Advance to the next key byte: rotate right by one byte
  function automatic logic [127:0] key_rotr8(input logic [127:0] key);
    return {key[7:0], key[127:8]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin arbiter. Grant is combinational and
//                gated by en_i; the last-served pointer moves on any grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] grant_o
);

  // 1 means requester 1 was served last, so requester 0 wins a tie
  logic last_q;
  logic [1:0] grant_d;

  // Tie goes to the requester not served last; a lone request always wins
  always_comb begin
    grant_d = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) begin
        grant_d = last_q ? 2'b01 : 2'b10;
      end else begin
        grant_d = req_i;
      end
    end
  end

  assign grant_o = grant_d;

  // Remember who was served; reset favours requester 0 first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (|grant_d) begin
      last_q <= grant_d[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/serdes_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : serdes_frame_scheduler
//  Description : Arbitrates two byte-pair requesters onto a bit-serial
//                encryptor core, serializes operands MSB first, captures the
//                serial ciphertext, and returns it with an error flag. A core
//                that fails to signal done is reset and the frame reported
//                as errored with the key left unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module serdes_frame_scheduler
  import serdes_sched_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [7:0]   req0_a,
  input  logic [7:0]   req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [7:0]   req1_a,
  input  logic [7:0]   req1_b,
  output logic         req1_ready,
  output logic         rsp_valid,
  output logic [7:0]   rsp_data,
  output logic         rsp_id,
  output logic         rsp_err,
  input  logic         rsp_ready,
  output logic         core_start,
  output logic         core_a_bit,
  output logic         core_b_bit,
  input  logic         core_cipher,
  input  logic         core_done,
  output logic         core_rst,
  output logic [127:0] core_key,
  input  logic         key_load,
  input  logic [127:0] key_in
);

  state_e         state_q;
  logic [4:0]     cyc_q;
  logic [7:0]     a_sh_q;
  logic [7:0]     b_sh_q;
  logic [7:0]     cap_q;
  logic           id_q;
  logic           core_start_q;
  logic           a_bit_q;
  logic           b_bit_q;
  logic           rsp_valid_q;
  logic [7:0]     rsp_data_q;
  logic           rsp_id_q;
  logic           rsp_err_q;
  logic [127:0]   key_q;

  logic           grant_en;
  logic [1:0]     grant;
  logic           accept;
  logic [7:0]     cap_next;

  // Grants only in IDLE, out of reset, and never on a key-load cycle
  assign grant_en = rst_n & (state_q == ST_IDLE) & ~key_load;
  assign accept   = |grant;
  assign cap_next = {cap_q[6:0], core_cipher};

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   ({req1_valid, req0_valid}),
    .en_i    (grant_en),
    .grant_o (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_err    = rsp_err_q;
  assign core_start = core_start_q;
  assign core_a_bit = a_bit_q;
  assign core_b_bit = b_bit_q;
  assign core_key   = key_q;
  assign core_rst   = ~rst_n | (state_q == ST_RECOVER);

  // Frame sequencer: one counter tracks the frame cycle Cn, all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cyc_q        <= 5'd0;
      a_sh_q       <= 8'd0;
      b_sh_q       <= 8'd0;
      cap_q        <= 8'd0;
      id_q         <= 1'b0;
      core_start_q <= 1'b0;
      a_bit_q      <= 1'b0;
      b_bit_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 8'd0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      key_q        <= DEFAULT_KEY;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_load) begin
            key_q <= key_in;
          end else if (accept) begin
            a_sh_q       <= grant[1] ? req1_a : req0_a;
            b_sh_q       <= grant[1] ? req1_b : req0_b;
            id_q         <= grant[1];
            cyc_q        <= 5'd0;
            core_start_q <= 1'b1;
            state_q      <= ST_START;
          end
        end

        ST_START: begin
          core_start_q <= 1'b0;
          a_bit_q      <= a_sh_q[7];
          b_bit_q      <= b_sh_q[7];
          a_sh_q       <= {a_sh_q[6:0], 1'b0};
          b_sh_q       <= {b_sh_q[6:0], 1'b0};
          cyc_q        <= cyc_inc(cyc_q);
          state_q      <= ST_SHIFT;
        end

        ST_SHIFT: begin
          cyc_q <= cyc_inc(cyc_q);
          if (cyc_q == SHIFT_LAST) begin
            a_bit_q <= 1'b0;
            b_bit_q <= 1'b0;
            state_q <= ST_WAIT;
          end else begin
            a_bit_q <= a_sh_q[7];
            b_bit_q <= b_sh_q[7];
            a_sh_q  <= {a_sh_q[6:0], 1'b0};
            b_sh_q  <= {b_sh_q[6:0], 1'b0};
          end
        end

        ST_WAIT: begin
          cyc_q <= cyc_inc(cyc_q);
          if (cyc_q == WAIT_LAST) begin
            state_q <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          cap_q <= cap_next;
          cyc_q <= cyc_inc(cyc_q);
          if (cyc_q == CAP_LAST) begin
            // done is judged together with the final cipher bit
            if (core_done) begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= cap_next;
              rsp_id_q    <= id_q;
              rsp_err_q   <= 1'b0;
              key_q       <= key_rotr8(key_q);
              state_q     <= ST_RESPOND;
            end else begin
              state_q     <= ST_RECOVER;
            end
          end
        end

        // Never entered in normal flow; if it is, treat the frame as failed
        ST_CHECK: begin
          cyc_q   <= CAP_LAST + 5'd1;
          state_q <= ST_RECOVER;
        end

        ST_RECOVER: begin
          cyc_q <= cyc_inc(cyc_q);
          if (cyc_q == RECOVER_EXIT) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= 8'h00;
            rsp_id_q    <= id_q;
            rsp_err_q   <= 1'b1;
            state_q     <= ST_RESPOND;
          end
        end

        ST_RESPOND: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serdes_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serdes_frame_scheduler
//  Description : Scoreboard bench for serdes_frame_scheduler with a
//                behavioural bit-serial core (cipher = a ^ b ^ key byte).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serdes_frame_scheduler;

  localparam logic [127:0] RESET_KEY = 128'hA1B2C3D4E5F60123456789ABCDEF1234;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic [7:0]   req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         rsp_valid;
  logic [7:0]   rsp_data;
  logic         rsp_id;
  logic         rsp_err;
  logic         rsp_ready;
  logic         core_start, core_a_bit, core_b_bit;
  logic         core_cipher, core_done;
  logic         core_rst;
  logic [127:0] core_key;
  logic         key_load;
  logic [127:0] key_in;

  serdes_frame_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_ready  (req1_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id),
    .rsp_err     (rsp_err),
    .rsp_ready   (rsp_ready),
    .core_start  (core_start),
    .core_a_bit  (core_a_bit),
    .core_b_bit  (core_b_bit),
    .core_cipher (core_cipher),
    .core_done   (core_done),
    .core_rst    (core_rst),
    .core_key    (core_key),
    .key_load    (key_load),
    .key_in      (key_in)
  );

  typedef struct {
    logic [7:0]   data;
    logic         id;
    logic         err;
    logic [127:0] key;
    int unsigned  t;
  } exp_t;

  exp_t         q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int unsigned  cycle = 0;
  int           hold_cycles = 0;
  logic         core_fail = 1'b0;

  // Reference model state
  logic [127:0] model_key = RESET_KEY;
  logic         last_id = 1'b1;
  logic         pend0 = 1'b0, pend1 = 1'b0;
  logic [7:0]   pa0, pb0, pa1, pb1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Behavioural encryptor core: collect 8 bit pairs, 2 idle cycles, stream result
  initial begin : core_model
    logic [7:0] ca, cb, cc;
    logic       fail, abort;
    core_cipher = 1'b0;
    core_done   = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (rst_n && core_start) begin
        fail = core_fail; abort = 1'b0; ca = 8'd0; cb = 8'd0;
        for (int k = 0; k < 8; k++) begin
          @(negedge clk); #2;
          if (core_rst) begin abort = 1'b1; break; end
          ca = {ca[6:0], core_a_bit};
          cb = {cb[6:0], core_b_bit};
        end
        for (int k = 0; k < 2 && !abort; k++) begin
          @(negedge clk); #2;
          if (core_rst) abort = 1'b1;
        end
        cc = ca ^ cb ^ core_key[7:0];
        for (int j = 0; j < 8 && !abort; j++) begin
          @(negedge clk); #2;
          if (core_rst) abort = 1'b1;
          else begin
            core_cipher = cc[7-j];
            core_done   = (j == 7) && !fail;
          end
        end
        if (!abort) begin @(negedge clk); #2; end
        core_cipher = 1'b0;
        core_done   = 1'b0;
      end
    end
  end

  // Consumer backpressure: optional forced stall, then random ready
  initial begin : consumer
    int stall_cnt;
    stall_cnt = 0;
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rsp_valid && stall_cnt < hold_cycles) begin
        rsp_ready = 1'b0;
        stall_cnt++;
      end else begin
        if (!rsp_valid) stall_cnt = 0;
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: compare every presented response against the scoreboard head
  initial begin : monitor
    exp_t e;
    int   crst_run;
    logic prev_valid, prev_hs, first;
    crst_run = 0; prev_valid = 1'b0; prev_hs = 1'b0;
    forever begin
      @(negedge clk); #3;
      if (!rst_n) begin
        crst_run = 0; prev_valid = 1'b0; prev_hs = 1'b0;
        continue;
      end
      if (core_rst) crst_run++;
      else if (crst_run != 0) begin
        chk("core_rst_len", 128'(crst_run), 128'd2);
        crst_run = 0;
      end
      if (rsp_valid) begin
        chk("quiet_during_rsp", {125'd0, req1_ready, req0_ready, core_start}, 128'd0);
        first = !prev_valid || prev_hs;
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_rsp: got data 0x%0h id %0d, expected no response", rsp_data, rsp_id);
        end else begin
          e = q[0];
          chk("rsp_data", 128'(rsp_data), 128'(e.data));
          chk("rsp_id",   128'(rsp_id),   128'(e.id));
          chk("rsp_err",  128'(rsp_err),  128'(e.err));
          if (first) begin
            chk("latency", 128'(cycle - e.t), e.err ? 128'd22 : 128'd20);
            chk("core_key", core_key, e.key);
          end
          if (rsp_ready) void'(q.pop_front());
        end
        prev_hs = rsp_ready;
      end else begin
        prev_hs = 1'b0;
      end
      prev_valid = rsp_valid;
    end
  end

  // One IDLE-cycle of stimulus; on an accept, follow the frame until its response is taken
  task automatic step(input logic w0, input logic [7:0] a0, input logic [7:0] b0,
                      input logic w1, input logic [7:0] a1, input logic [7:0] b1,
                      input logic kl, input logic [127:0] kin, input logic fail);
    logic [1:0] exp_g;
    logic       hs;
    exp_t       it;
    if (w0 && !pend0) begin pend0 = 1'b1; pa0 = a0; pb0 = b0; end
    if (w1 && !pend1) begin pend1 = 1'b1; pa1 = a1; pb1 = b1; end
    key_load = kl; key_in = kin; core_fail = fail;
    req0_valid = pend0; req0_a = pa0; req0_b = pb0;
    req1_valid = pend1; req1_a = pa1; req1_b = pb1;
    exp_g = 2'b00;
    if (!kl) begin
      if (pend0 && pend1) exp_g = last_id ? 2'b01 : 2'b10;
      else if (pend0)     exp_g = 2'b01;
      else if (pend1)     exp_g = 2'b10;
    end
    #1;
    chk("grant", 128'({req1_ready, req0_ready}), 128'(exp_g));
    if (kl) model_key = kin;
    if (exp_g != 2'b00) begin
      it.id  = exp_g[1];
      it.err = fail;
      it.data = fail ? 8'h00 : ((it.id ? (pa1 ^ pb1) : (pa0 ^ pb0)) ^ model_key[7:0]);
      if (!fail) model_key = {model_key[7:0], model_key[127:8]};
      it.key = model_key;
      it.t   = cycle;
      q.push_back(it);
      last_id = it.id;
      if (it.id) pend1 = 1'b0; else pend0 = 1'b0;
      @(negedge clk);
      key_load = 1'b0;
      hs = 1'b0;
      for (int i = 0; i < 200; i++) begin
        req0_valid = pend0; req1_valid = pend1;
        #1;
        chk("no_grant_busy", 128'({req1_ready, req0_ready}), 128'd0);
        if (rsp_valid && rsp_ready) begin hs = 1'b1; @(negedge clk); break; end
        @(negedge clk);
      end
      if (!hs) begin
        n_vec++; n_err++;
        $display("FAIL rsp_timeout: got no response handshake, expected one within 200 cycles");
      end
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; key_load = 1'b0;
    @(negedge clk); @(negedge clk);
    q.delete();
    model_key = RESET_KEY; last_id = 1'b1; pend0 = 1'b0; pend1 = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin : main
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 8'd0; req0_b = 8'd0; req1_a = 8'd0; req1_b = 8'd0;
    pa0 = 8'd0; pb0 = 8'd0; pa1 = 8'd0; pb1 = 8'd0;
    key_load = 1'b0; key_in = 128'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rsp_valid",  128'(rsp_valid), 128'd0);
    chk("rst_core_rst",   128'(core_rst), 128'd1);
    chk("rst_core_start", 128'(core_start), 128'd0);
    chk("rst_core_bits",  128'({core_a_bit, core_b_bit}), 128'd0);
    chk("rst_key",        core_key, RESET_KEY);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("core_rst_release", 128'(core_rst), 128'd0);
    @(negedge clk);

    // Known-answer frames: 0xF0/0x0F -> 0xCB, then 0x00/0x00 -> 0x12
    step(1'b1, 8'hF0, 8'h0F, 1'b0, 8'h00, 8'h00, 1'b0, 128'd0, 1'b0);
    chk("key_byte_after_1", 128'(core_key[7:0]), 128'h12);
    step(1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 128'd0, 1'b0);

    // Simultaneous requests after reset: req0 first, then req1
    do_reset();
    step(1'b1, 8'h11, 8'h22, 1'b1, 8'h33, 8'h44, 1'b0, 128'd0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 128'd0, 1'b0);

    // Held response with a waiting requester
    hold_cycles = 10;
    step(1'b1, 8'hA5, 8'h3C, 1'b1, 8'h5A, 8'hC3, 1'b0, 128'd0, 1'b0);
    hold_cycles = 0;
    step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 128'd0, 1'b0);

    // Core never completes
    step(1'b1, 8'h77, 8'h88, 1'b0, 8'h00, 8'h00, 1'b0, 128'd0, 1'b1);

    // Reset in C5 abandons the frame, then key load and a fresh frame -> 0x54
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 8'h9C; req0_b = 8'h3E;
    #1;
    chk("pre_abort_grant", 128'(req0_ready), 128'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (5) @(negedge clk);
    do_reset();
    step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, {120'd0, 8'h55}, 1'b0);
    chk("key_loaded", core_key, {120'd0, 8'h55});
    step(1'b1, 8'h01, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 128'd0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      hold_cycles = $urandom_range(0, 4);
      step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 7) == 0), {$urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 5) == 0));
    end
    hold_cycles = 0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (40) @(negedge clk);
    chk("scoreboard_drained", 128'(q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
